riscv_selftest_seq: RTL and testbench
=====================================

RISCV_SELFTEST_SEQ -- requirements
Module: riscv_selftest_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath/word width.
REQ-002 SHALL have parameter IMEM_DEPTH, default 64, meaning instruction-memory words; AW = $clog2(IMEM_DEPTH).
REQ-003 SHALL have parameter NUM_CHECKS, default 8, meaning expected-value table entries; CIW = $clog2(NUM_CHECKS).
REQ-004 SHALL have parameter CW, default 16, meaning cycle-budget counter width.
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  system clock, rising edge.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 start  in  1  begin a test when IDLE or DONE.
REQ-009 run_cycles  in  CW  core cycles to execute, sampled when start is accepted.
REQ-010 load_valid/load_ready  in/out  1  program-word handshake.
REQ-011 load_data  in  XLEN  program word; load_last  in  1  final word.
REQ-012 chk_valid/chk_ready  in/out  1  expected-value handshake.
REQ-013 chk_reg  in  5  register index; chk_value  in  XLEN  expected contents.
REQ-014 imem_we  out  1,  imem_waddr  out  AW,  imem_wdata  out  XLEN  instruction-memory write port.
REQ-015 core_rst  out  1  active-high core reset; core_run  out  1  core clock-enable.
REQ-016 rf_raddr  out  5  debug RF read address; rf_rdata  in  XLEN  combinational read data.
REQ-017 busy, done, pass, load_ovf  out  1 each; fail_idx  out  CIW; fail_value  out  XLEN.

Function
REQ-018 SHALL implement states IDLE, LOAD, CORE_RST, RUN, CHECK, DONE.
REQ-019 IDLE/DONE + start: clear word and check counters, load_ovf, fail fields; latch run_cycles; go to LOAD.
REQ-020 A start asserted in any other state SHALL be ignored.
REQ-021 In LOAD, load_ready SHALL be 1; each accepted word SHALL drive imem_we=1, imem_waddr=word count, imem_wdata=load_data in the same cycle.
REQ-022 Accepting load_last SHALL move to CORE_RST next cycle.
REQ-023 Accepting a word at address IMEM_DEPTH-1 without load_last SHALL be treated as last and SHALL set load_ovf.
REQ-024 In LOAD, chk_ready SHALL equal (stored entries < NUM_CHECKS); accepted pairs SHALL be stored in arrival order.
REQ-025 In all other states, load_ready and chk_ready SHALL be 0.
REQ-026 core_rst SHALL be 1 in IDLE, LOAD and CORE_RST, and 0 in RUN, CHECK and DONE.
REQ-027 CORE_RST SHALL last exactly 2 cycles.
REQ-028 In RUN, core_run SHALL be 1 for exactly the latched run_cycles cycles, then the block SHALL go to CHECK.
REQ-029 If the latched run_cycles is 0, CORE_RST SHALL go directly to CHECK.
REQ-030 core_run SHALL be 0 outside RUN, freezing core state during CHECK.
REQ-031 CHECK SHALL evaluate one entry per cycle, index 0 upward, with rf_raddr = entry reg and compare rf_rdata == entry value in that cycle.
REQ-032 On the first mismatch: record fail_idx and fail_value=rf_rdata; pass SHALL be 0; go to DONE.
REQ-033 After all entries match (including zero entries), pass SHALL be 1 and the block SHALL go to DONE.
REQ-034 done SHALL be 1 only in DONE; busy SHALL be 1 in LOAD..CHECK.
REQ-035 pass, fail_idx, fail_value and load_ovf SHALL hold until the next accepted start.

Reset
REQ-036 rst SHALL force IDLE asynchronously, from any state including mid-RUN.
REQ-037 Under rst: core_rst=1, core_run=0, imem_we=0, every handshake ready=0, all status outputs 0, check table count 0.

Structure
REQ-038 Package riscv_selftest_pkg SHALL hold the state enum and the check-entry struct {reg[4:0], value[XLEN-1:0]}.
REQ-039 Sub-module selftest_check_table SHALL hold the check entries: write pointer, count/full flag, indexed read.

Verification
REQ-040 Scenario 1: 7-word addi/add/sub program, run_cycles=7, checks x1=10, x2=5, x3=15, x4=5 -> done=1, pass=1.
REQ-041 Scenario 2: same program, check 2 expects x3=16 -> pass=0, fail_idx=2, fail_value=15, DONE one cycle after check 2 is evaluated.
REQ-042 Scenario 3: IMEM_DEPTH=16, 20 words streamed, no last -> exactly 16 imem writes, load_ovf=1, load_ready=0 after the 16th word.
REQ-043 Scenario 4: 9 checks offered with NUM_CHECKS=8 -> chk_ready=0 after 8 accepted; zero checks offered -> pass=1.
REQ-044 Scenario 5: rst asserted at RUN cycle 3 -> IDLE immediately, core_rst=1, core_run=0, busy=0; a following start completes normally.
REQ-045 Scenario 6: run_cycles=0 -> CORE_RST goes to CHECK with no core_run pulse; a check expecting x0=0 passes.

Source files
------------

// File: rtl/riscv_selftest_pkg.sv
// rtl/riscv_selftest_pkg.sv - shared types for the RISC-V self-test sequencer
// State encoding and the stored check entry (register index plus expected value).
package riscv_selftest_pkg;

  // Check values are stored zero-extended to this width so the table is XLEN-agnostic.
  localparam int MAX_XLEN = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CORE_RST,
    ST_RUN,
    ST_CHECK,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [4:0]          reg_idx;
    logic [MAX_XLEN-1:0] value;
  } chk_entry_t;

  function automatic chk_entry_t make_entry(input logic [4:0] r, input logic [MAX_XLEN-1:0] v);
    chk_entry_t e;
    e.reg_idx = r;
    e.value   = v;
    return e;
  endfunction

endpackage

// File: rtl/riscv_selftest_seq_check_table.sv
// rtl/riscv_selftest_seq_check_table.sv - expected-value table for the self-test sequencer
// Entries are appended in arrival order and read back by index during the check phase.
module selftest_check_table
  import riscv_selftest_pkg::*;
#(
  parameter int NUM_CHECKS = 8,
  localparam int CIW = $clog2(NUM_CHECKS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  chk_entry_t       wr_entry,
  input  logic [CIW-1:0]   rd_idx,
  output chk_entry_t       rd_entry,
  output logic [CIW:0]     count,
  output logic             full
);

  chk_entry_t     entries [NUM_CHECKS];
  logic [CIW:0]   wr_ptr;

  assign count    = wr_ptr;
  assign full     = (wr_ptr == (CIW+1)'(NUM_CHECKS));
  assign rd_entry = entries[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
    end else if (wr_en && !full) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Payload storage carries no reset; only entries below count are ever read meaningfully.
  always_ff @(posedge clk) begin
    if (wr_en && !full) begin
      entries[wr_ptr[CIW-1:0]] <= wr_entry;
    end
  end

endmodule

// File: rtl/riscv_selftest_seq.sv
// rtl/riscv_selftest_seq.sv - loads a program into a core, runs it for a cycle budget,
// then compares selected register-file contents against an expected-value table.
module riscv_selftest_seq
  import riscv_selftest_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int IMEM_DEPTH = 64,
  parameter int NUM_CHECKS = 8,
  parameter int CW         = 16,
  localparam int AW        = $clog2(IMEM_DEPTH),
  localparam int CIW       = $clog2(NUM_CHECKS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CW-1:0]    run_cycles,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [XLEN-1:0]  load_data,
  input  logic             load_last,
  input  logic             chk_valid,
  output logic             chk_ready,
  input  logic [4:0]       chk_reg,
  input  logic [XLEN-1:0]  chk_value,
  output logic             imem_we,
  output logic [AW-1:0]    imem_waddr,
  output logic [XLEN-1:0]  imem_wdata,
  output logic             core_rst,
  output logic             core_run,
  output logic [4:0]       rf_raddr,
  input  logic [XLEN-1:0]  rf_rdata,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             load_ovf,
  output logic [CIW-1:0]   fail_idx,
  output logic [XLEN-1:0]  fail_value
);

  state_t          state, state_n;
  logic [AW-1:0]   word_cnt;
  logic [CW-1:0]   run_lat;
  logic [CW-1:0]   cyc_cnt;
  logic            crst_cnt;
  logic [CIW-1:0]  chk_idx;

  logic            start_acc;
  logic            ld_fire;
  logic            ovf_set;
  logic            chk_fire;
  logic            chk_pass;
  logic            chk_fail;

  chk_entry_t      rd_entry;
  logic [CIW:0]    chk_count;
  logic            chk_full;

  selftest_check_table #(
    .NUM_CHECKS (NUM_CHECKS)
  ) u_table (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_acc),
    .wr_en    (chk_fire),
    .wr_entry (make_entry(chk_reg, MAX_XLEN'(chk_value))),
    .rd_idx   (chk_idx),
    .rd_entry (rd_entry),
    .count    (chk_count),
    .full     (chk_full)
  );

  assign imem_waddr = word_cnt;
  assign imem_wdata = load_data;

  always_comb begin
    state_n    = state;
    start_acc  = 1'b0;
    ld_fire    = 1'b0;
    ovf_set    = 1'b0;
    chk_fire   = 1'b0;
    chk_pass   = 1'b0;
    chk_fail   = 1'b0;
    load_ready = 1'b0;
    chk_ready  = 1'b0;
    imem_we    = 1'b0;
    core_rst   = 1'b0;
    core_run   = 1'b0;
    rf_raddr   = 5'd0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state)
      ST_IDLE: begin
        core_rst = 1'b1;
        if (start) begin
          start_acc = 1'b1;
          state_n   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        core_rst   = 1'b1;
        busy       = 1'b1;
        load_ready = 1'b1;
        chk_ready  = !chk_full;
        chk_fire   = chk_valid && !chk_full;
        ld_fire    = load_valid;
        imem_we    = load_valid;
        // The last memory slot ends the load even without load_last.
        if (load_valid) begin
          if (load_last) begin
            state_n = ST_CORE_RST;
          end else if (word_cnt == AW'(IMEM_DEPTH - 1)) begin
            ovf_set = 1'b1;
            state_n = ST_CORE_RST;
          end
        end
      end
      ST_CORE_RST: begin
        core_rst = 1'b1;
        busy     = 1'b1;
        if (crst_cnt) begin
          state_n = (run_lat == '0) ? ST_CHECK : ST_RUN;
        end
      end
      ST_RUN: begin
        busy     = 1'b1;
        core_run = 1'b1;
        if (cyc_cnt == run_lat - 1'b1) begin
          state_n = ST_CHECK;
        end
      end
      ST_CHECK: begin
        busy     = 1'b1;
        rf_raddr = rd_entry.reg_idx;
        if (chk_count == '0) begin
          chk_pass = 1'b1;
          state_n  = ST_DONE;
        end else if (rd_entry.value != MAX_XLEN'(rf_rdata)) begin
          chk_fail = 1'b1;
          state_n  = ST_DONE;
        end else if ((CIW+1)'(chk_idx) == chk_count - 1'b1) begin
          chk_pass = 1'b1;
          state_n  = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          start_acc = 1'b1;
          state_n   = ST_LOAD;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      word_cnt   <= '0;
      run_lat    <= '0;
      cyc_cnt    <= '0;
      crst_cnt   <= 1'b0;
      chk_idx    <= '0;
      pass       <= 1'b0;
      load_ovf   <= 1'b0;
      fail_idx   <= '0;
      fail_value <= '0;
    end else begin
      state    <= state_n;
      crst_cnt <= (state == ST_CORE_RST) ? ~crst_cnt : 1'b0;
      cyc_cnt  <= (state == ST_RUN) ? cyc_cnt + 1'b1 : '0;
      chk_idx  <= (state == ST_CHECK) ? chk_idx + 1'b1 : '0;

      if (start_acc) begin
        word_cnt   <= '0;
        run_lat    <= run_cycles;
        pass       <= 1'b0;
        load_ovf   <= 1'b0;
        fail_idx   <= '0;
        fail_value <= '0;
      end
      if (ld_fire) begin
        word_cnt <= word_cnt + 1'b1;
      end
      if (ovf_set) begin
        load_ovf <= 1'b1;
      end
      if (chk_pass) begin
        pass <= 1'b1;
      end
      if (chk_fail) begin
        fail_idx   <= chk_idx;
        fail_value <= rf_rdata;
      end
    end
  end

endmodule

// File: tb/tb_riscv_selftest_seq.sv
// tb/tb_riscv_selftest_seq.sv - self-checking bench for riscv_selftest_seq
// A tiny addi/add/sub core model stands in for the core under test.
module tb_riscv_selftest_seq;

  localparam int XLEN = 32;
  localparam int DEPTH = 16;
  localparam int NCHK = 8;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CW-1:0]     run_cycles;
  logic              load_valid, load_ready, load_last;
  logic [XLEN-1:0]   load_data;
  logic              chk_valid, chk_ready;
  logic [4:0]        chk_reg;
  logic [XLEN-1:0]   chk_value;
  logic              imem_we;
  logic [3:0]        imem_waddr;
  logic [XLEN-1:0]   imem_wdata;
  logic              core_rst, core_run;
  logic [4:0]        rf_raddr;
  logic [XLEN-1:0]   rf_rdata;
  logic              busy, done, pass, load_ovf;
  logic [2:0]        fail_idx;
  logic [XLEN-1:0]   fail_value;

  int checks = 0;
  int errors = 0;

  riscv_selftest_seq #(
    .XLEN(XLEN), .IMEM_DEPTH(DEPTH), .NUM_CHECKS(NCHK), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .run_cycles(run_cycles),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .load_last(load_last), .chk_valid(chk_valid), .chk_ready(chk_ready),
    .chk_reg(chk_reg), .chk_value(chk_value), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .core_rst(core_rst),
    .core_run(core_run), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .busy(busy), .done(done), .pass(pass), .load_ovf(load_ovf),
    .fail_idx(fail_idx), .fail_value(fail_value)
  );

  always #5 clk = ~clk;

  // Core model: one instruction per enabled cycle, cleared while core_rst is high.
  logic [31:0] imem [DEPTH];
  logic [31:0] regs [32];
  logic [3:0]  pc;
  logic        wr_clr;
  int          imem_writes;

  function automatic logic [31:0] alu(input logic [31:0] ins);
    logic [31:0] a, b;
    a = regs[ins[19:15]];
    b = regs[ins[24:20]];
    if (ins[6:0] == 7'h13) return a + {{20{ins[31]}}, ins[31:20]};
    return ins[30] ? a - b : a + b;
  endfunction

  always @(posedge clk) begin
    if (wr_clr) begin
      imem_writes <= 0;
      for (int i = 0; i < DEPTH; i++) imem[i] <= 32'h0;
    end else if (imem_we) begin
      imem[imem_waddr] <= imem_wdata;
      imem_writes <= imem_writes + 1;
    end
    if (core_rst) begin
      pc <= 4'd0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (core_run) begin
      pc <= pc + 4'd1;
      if ((imem[pc][6:0] == 7'h13 || imem[pc][6:0] == 7'h33) && imem[pc][11:7] != 5'd0)
        regs[imem[pc][11:7]] <= alu(imem[pc]);
    end
  end

  assign rf_rdata = regs[rf_raddr];

  function automatic logic [31:0] enc_i(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'h13};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  logic [31:0] prog [7];

  typedef struct packed {
    logic [15:0]      rc;
    logic [2:0]       nchk;
    logic [3:0][4:0]  regs;
    logic [3:0][31:0] vals;
    logic             exp_pass;
    logic [2:0]       exp_idx;
    logic [31:0]      exp_fval;
    logic [3:0]       exp_cc;
  } vec_t;

  vec_t vecs [7];

  function automatic vec_t mk(input logic [15:0] rc, input logic [2:0] n,
                              input logic [3:0][4:0] r, input logic [3:0][31:0] v,
                              input logic p, input logic [2:0] fi, input logic [31:0] fv,
                              input logic [3:0] cc);
    vec_t t;
    t.rc = rc; t.nchk = n; t.regs = r; t.vals = v;
    t.exp_pass = p; t.exp_idx = fi; t.exp_fval = fv; t.exp_cc = cc;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic pulse_clr();
    wr_clr = 1'b1;
    @(negedge clk);
    wr_clr = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] rc);
    start = 1'b1;
    run_cycles = rc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_chk(input logic [4:0] r, input logic [31:0] v, output bit ok);
    chk_valid = 1'b1; chk_reg = r; chk_value = v;
    ok = chk_ready;
    if (ok) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic last, output bit ok);
    load_valid = 1'b1; load_data = w; load_last = last;
    ok = load_ready;
    if (ok) begin
      @(posedge clk);
      @(negedge clk);
    end
    load_valid = 1'b0;
    load_last = 1'b0;
  endtask

  task automatic load_prog();
    bit ok;
    for (int i = 0; i < 7; i++) begin
      send_word(prog[i], i == 6, ok);
      check("load_accept", ok, 1);
    end
  endtask

  task automatic wait_done(output int rc, output int cr, output int cc, output bit to);
    rc = 0; cr = 0; cc = 0; to = 1'b1;
    for (int t = 0; t < 400; t++) begin
      if (done) begin
        to = 1'b0;
        break;
      end
      if (core_run) rc++;
      if (busy && core_rst && !load_ready) cr++;
      if (busy && !core_rst && !core_run) cc++;
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    int rc, cr, cc;
    bit to;
    pulse_clr();
    do_start(v.rc);
    for (int k = 0; k < 4; k++) begin
      if (k < int'(v.nchk)) begin
        send_chk(v.regs[k], v.vals[k], ok);
        check("chk_accept", ok, 1);
      end
    end
    load_prog();
    wait_done(rc, cr, cc, to);
    check("timeout", to, 0);
    check("done", done, 1);
    check("busy_done", busy, 0);
    check("pass", pass, v.exp_pass);
    check("fail_idx", fail_idx, v.exp_idx);
    check("fail_value", fail_value, v.exp_fval);
    check("load_ovf", load_ovf, 0);
    check("run_len", rc, v.rc);
    check("core_rst_len", cr, 2);
    check("check_len", cc, v.exp_cc);
    check("imem_writes", imem_writes, 7);
  endtask

  initial begin
    bit ok;
    int acc, rc, cr, cc;
    bit to;
    logic [31:0] final_regs [8];

    rst = 1'b1; start = 1'b0; run_cycles = '0; wr_clr = 1'b0;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    chk_valid = 1'b0; chk_reg = '0; chk_value = '0;

    prog[0] = enc_i(5'd1, 5'd0, 12'd10);
    prog[1] = enc_i(5'd2, 5'd0, 12'd5);
    prog[2] = enc_r(7'h00, 5'd3, 5'd1, 5'd2);
    prog[3] = enc_r(7'h20, 5'd4, 5'd3, 5'd1);
    prog[4] = enc_i(5'd5, 5'd0, 12'd1);
    prog[5] = enc_i(5'd6, 5'd0, 12'd2);
    prog[6] = enc_r(7'h00, 5'd7, 5'd5, 5'd6);
    final_regs = '{32'd0, 32'd10, 32'd5, 32'd15, 32'd5, 32'd1, 32'd2, 32'd3};

    vecs[0] = mk(16'd7, 3'd4, {5'd4, 5'd3, 5'd2, 5'd1}, {32'd5, 32'd15, 32'd5, 32'd10}, 1'b1, 3'd0, 32'd0, 4'd4);
    vecs[1] = mk(16'd7, 3'd4, {5'd4, 5'd3, 5'd2, 5'd1}, {32'd5, 32'd16, 32'd5, 32'd10}, 1'b0, 3'd2, 32'd15, 4'd3);
    vecs[2] = mk(16'd3, 3'd2, {5'd0, 5'd0, 5'd4, 5'd3}, {32'd0, 32'd0, 32'd0, 32'd15}, 1'b1, 3'd0, 32'd0, 4'd2);
    vecs[3] = mk(16'd2, 3'd1, {5'd0, 5'd0, 5'd0, 5'd3}, {32'd0, 32'd0, 32'd0, 32'd15}, 1'b0, 3'd0, 32'd0, 4'd1);
    vecs[4] = mk(16'd0, 3'd1, {5'd0, 5'd0, 5'd0, 5'd0}, {32'd0, 32'd0, 32'd0, 32'd0}, 1'b1, 3'd0, 32'd0, 4'd1);
    vecs[5] = mk(16'd7, 3'd0, {5'd0, 5'd0, 5'd0, 5'd0}, {32'd0, 32'd0, 32'd0, 32'd0}, 1'b1, 3'd0, 32'd0, 4'd1);
    vecs[6] = mk(16'd9, 3'd2, {5'd0, 5'd0, 5'd1, 5'd7}, {32'd0, 32'd0, 32'd10, 32'd3}, 1'b1, 3'd0, 32'd0, 4'd2);

    repeat (2) @(negedge clk);
    check("rst_core_rst", core_rst, 1);
    check("rst_core_run", core_run, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_load_ovf", load_ovf, 0);
    check("rst_load_ready", load_ready, 0);
    check("rst_chk_ready", chk_ready, 0);
    check("rst_imem_we", imem_we, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // start outside IDLE/DONE must not restart the load
    pulse_clr();
    do_start(16'd7);
    send_word(prog[0], 1'b0, ok);
    do_start(16'd7);
    for (int i = 1; i < 7; i++) send_word(prog[i], i == 6, ok);
    wait_done(rc, cr, cc, to);
    check("ign_start_writes", imem_writes, 7);
    check("ign_start_run", rc, 7);

    // program overflow: 20 words, no last, 16-word memory
    pulse_clr();
    do_start(16'd7);
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      send_word((i < 7) ? prog[i] : 32'h13, 1'b0, ok);
      if (!ok) break;
      acc++;
    end
    check("ovf_accepted", acc, 16);
    check("ovf_writes", imem_writes, 16);
    check("ovf_load_ready", load_ready, 0);
    wait_done(rc, cr, cc, to);
    check("ovf_timeout", to, 0);
    check("ovf_flag", load_ovf, 1);
    check("ovf_pass", pass, 1);

    // check table capacity: 9 offered, 8 stored
    pulse_clr();
    do_start(16'd7);
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      send_chk(5'(i % 8), final_regs[i % 8], ok);
      if (ok) acc++;
    end
    check("tbl_accepted", acc, 8);
    check("tbl_chk_ready", chk_ready, 0);
    load_prog();
    wait_done(rc, cr, cc, to);
    check("tbl_pass", pass, 1);
    check("tbl_check_len", cc, 8);

    // asynchronous reset during the third RUN cycle
    pulse_clr();
    do_start(16'd7);
    load_prog();
    acc = 0;
    for (int t = 0; t < 50 && acc < 3; t++) begin
      if (core_run) acc++;
      if (acc < 3) @(negedge clk);
    end
    check("mid_run_reached", acc, 3);
    rst = 1'b1;
    #1;
    check("mid_rst_core_rst", core_rst, 1);
    check("mid_rst_core_run", core_run, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_load_ready", load_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
